// File: rtl/pc_fetch.sv
// Program-counter fetch sequencer: IDLE/RUN/HALT control with absolute or
// PC-relative branch resolution through an external LUT and a saturating retire count.
module pc_fetch #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned LUT_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              halt,
  input  logic              branch_taken,
  input  logic              branch_rel,
  input  logic [LUT_AW-1:0] lut_idx,
  output logic [LUT_AW-1:0] lut_addr,
  input  logic [PC_W-1:0]   lut_data,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done,
  output logic [15:0]       instr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       cnt_inc;

  assign lut_addr = lut_idx;

  // Retire count sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          cnt_d = cnt_inc;
          if (halt) begin
            state_d = ST_HALT;
          end else if (branch_taken) begin
            // Relative targets add lut_data as two's complement; truncation gives the wrap.
            pc_d = branch_rel ? pc_q + lut_data : lut_data;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign instr_cnt = cnt_q;
  assign running   = (state_q == ST_RUN);
  assign done      = (state_q == ST_HALT);

endmodule
